// File: rtl/ps2_ascii_decode.sv
// ps2_ascii_decode: PS/2 set-2 scan bytes to ASCII, buffered in a show-ahead FIFO.
// Define PS2_TYPEMATIC_EN to pass key auto-repeats through; otherwise a repeated make is suppressed.
module ps2_ascii_decode #(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        scan_byte,
  input  logic              scan_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow,
  output logic              caps_state
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t r_state, w_state_nxt;
  logic w_make, w_brk, w_upper, w_emit;
  logic r_shift_l, r_shift_r, r_caps_held, r_char_valid;
  logic [7:0] r_char, w_char;
  logic [8:0] w_map;
  function automatic logic [8:0] map_code(input logic [7:0] c);
    case (c)
      8'h1C: map_code = {1'b1, "a"};  8'h32: map_code = {1'b1, "b"};
      8'h21: map_code = {1'b1, "c"};  8'h23: map_code = {1'b1, "d"};
      8'h24: map_code = {1'b1, "e"};  8'h2B: map_code = {1'b1, "f"};
      8'h34: map_code = {1'b1, "g"};  8'h33: map_code = {1'b1, "h"};
      8'h43: map_code = {1'b1, "i"};  8'h3B: map_code = {1'b1, "j"};
      8'h42: map_code = {1'b1, "k"};  8'h4B: map_code = {1'b1, "l"};
      8'h3A: map_code = {1'b1, "m"};  8'h31: map_code = {1'b1, "n"};
      8'h44: map_code = {1'b1, "o"};  8'h4D: map_code = {1'b1, "p"};
      8'h15: map_code = {1'b1, "q"};  8'h2D: map_code = {1'b1, "r"};
      8'h1B: map_code = {1'b1, "s"};  8'h2C: map_code = {1'b1, "t"};
      8'h3C: map_code = {1'b1, "u"};  8'h2A: map_code = {1'b1, "v"};
      8'h1D: map_code = {1'b1, "w"};  8'h22: map_code = {1'b1, "x"};
      8'h35: map_code = {1'b1, "y"};  8'h1A: map_code = {1'b1, "z"};
      8'h45: map_code = {1'b1, "0"};  8'h16: map_code = {1'b1, "1"};
      8'h1E: map_code = {1'b1, "2"};  8'h26: map_code = {1'b1, "3"};
      8'h25: map_code = {1'b1, "4"};  8'h2E: map_code = {1'b1, "5"};
      8'h36: map_code = {1'b1, "6"};  8'h3D: map_code = {1'b1, "7"};
      8'h3E: map_code = {1'b1, "8"};  8'h46: map_code = {1'b1, "9"};
      8'h29: map_code = {1'b1, 8'h20};
      8'h5A: map_code = {1'b1, 8'h0D};
      8'h66: map_code = {1'b1, 8'h08};
      default: map_code = 9'h000;
    endcase
  endfunction
  always_comb begin
    w_state_nxt = r_state;
    w_make = 1'b0;
    w_brk = 1'b0;
    if (scan_valid) begin
      case (r_state)
        IDLE: begin
          w_state_nxt = scan_byte == 8'hE0 ? EXT : (scan_byte == 8'hF0 ? BRK : IDLE);
          w_make = scan_byte != 8'hE0 && scan_byte != 8'hF0;
        end
        EXT: w_state_nxt = scan_byte == 8'hF0 ? EXT_BRK : IDLE;
        BRK: begin
          w_state_nxt = IDLE;
          w_brk = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  assign w_map = map_code(scan_byte);
  assign w_upper = (r_shift_l | r_shift_r) ^ caps_state;
  assign w_char = (w_upper && w_map[7:0] >= "a" && w_map[7:0] <= "z") ? w_map[7:0] - 8'h20 : w_map[7:0];
`ifdef PS2_TYPEMATIC_EN
  assign w_emit = w_make && w_map[8];
`else
  logic [7:0] r_last_make;
  assign w_emit = w_make && w_map[8] && scan_byte != r_last_make;
  always_ff @(posedge clk) begin
    if (!rst_n) r_last_make <= 8'h00;
    else if (w_emit) r_last_make <= scan_byte;
    else if (w_brk && scan_byte == r_last_make) r_last_make <= 8'h00;
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift_l <= 1'b0;
      r_shift_r <= 1'b0;
      caps_state <= 1'b0;
      r_caps_held <= 1'b0;
      r_char <= 8'h00;
      r_char_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_char <= w_char;
      r_char_valid <= w_emit;
      if (w_make && scan_byte == 8'h12) r_shift_l <= 1'b1;
      if (w_make && scan_byte == 8'h59) r_shift_r <= 1'b1;
      if (w_make && scan_byte == 8'h58 && !r_caps_held) begin
        caps_state <= ~caps_state;
        r_caps_held <= 1'b1;
      end
      if (w_brk && scan_byte == 8'h12) r_shift_l <= 1'b0;
      if (w_brk && scan_byte == 8'h59) r_shift_r <= 1'b0;
      if (w_brk && scan_byte == 8'h58) r_caps_held <= 1'b0;
    end
  end
  // Pointers carry one extra bit so full and empty differ
  logic [7:0] r_mem [2**ADDR_W];
  logic [ADDR_W:0] r_wp, r_rp;
  logic w_full, w_pop, w_push;
  assign fifo_count = r_wp - r_rp;
  assign w_full = fifo_count[ADDR_W];
  assign out_valid = r_wp != r_rp;
  assign out_data = out_valid ? r_mem[r_rp[ADDR_W-1:0]] : 8'h00;
  assign w_pop = out_valid && out_ready;
  assign w_push = r_char_valid && (!w_full || w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
      overflow <= 1'b0;
    end else begin
      r_wp <= r_wp + (ADDR_W+1)'(w_push);
      r_rp <= r_rp + (ADDR_W+1)'(w_pop);
      overflow <= r_char_valid && w_full && !w_pop;
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wp[ADDR_W-1:0]] <= r_char;
endmodule

// File: tb/tb_ps2_ascii_decode.sv
// tb_ps2_ascii_decode: scenario tasks plus a randomized stream checked against a byte-level keyboard model.
module tb_ps2_ascii_decode;
  logic clk = 0, rst_n = 0, scan_valid = 0, out_ready = 0;
  logic [7:0] scan_byte = 0, out_data;
  logic out_valid, overflow, caps_state;
  logic [3:0] fifo_count;
  int total = 0, bad = 0, ovf_cnt = 0;
  byte unsigned got[$], exp_q[$];
  byte unsigned letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  byte unsigned digits[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
  byte unsigned mods[6] = '{8'h12,8'h59,8'h58,8'h29,8'h5A,8'h66};
  bit m_ext, m_brk, m_shl, m_shr, m_caps, m_held;
  byte unsigned m_last;

  ps2_ascii_decode dut (.clk(clk), .rst_n(rst_n), .scan_byte(scan_byte), .scan_valid(scan_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .fifo_count(fifo_count),
    .overflow(overflow), .caps_state(caps_state));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
    if (overflow) ovf_cnt++;
  end

  function automatic int lookup(byte unsigned b, bit up);
    foreach (letters[i]) if (letters[i] == b) return (up ? 'h41 : 'h61) + i;
    foreach (digits[i]) if (digits[i] == b) return 'h30 + i;
    if (b == 8'h29) return 'h20;
    if (b == 8'h5A) return 'h0D;
    if (b == 8'h66) return 'h08;
    return -1;
  endfunction

  function automatic void model(byte unsigned b);
    int c;
    if (m_ext && !m_brk) begin
      if (b == 8'hF0) m_brk = 1; else m_ext = 0;
    end else if (m_ext) begin
      m_ext = 0; m_brk = 0;
    end else if (m_brk) begin
      m_brk = 0;
      if (b == 8'h12) m_shl = 0;
      if (b == 8'h59) m_shr = 0;
      if (b == 8'h58) m_held = 0;
      if (b == m_last) m_last = 0;
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (b == 8'h12) m_shl = 1;
      if (b == 8'h59) m_shr = 1;
      if (b == 8'h58 && !m_held) begin m_caps = !m_caps; m_held = 1; end
      c = lookup(b, (m_shl | m_shr) ^ m_caps);
`ifdef PS2_TYPEMATIC_EN
      if (c >= 0) exp_q.push_back(8'(c));
`else
      if (c >= 0 && b != m_last) begin exp_q.push_back(8'(c)); m_last = b; end
`endif
    end
  endfunction

  task automatic tick; @(posedge clk); #1; endtask

  task automatic send(input byte unsigned b);
    scan_byte = b; scan_valid = 1; model(b);
    tick;
    scan_valid = 0;
  endtask

  task automatic do_reset;
    rst_n = 0; scan_valid = 1; scan_byte = 8'h1C;
    repeat (2) tick;
    rst_n = 1; scan_valid = 0;
    {m_ext, m_brk, m_shl, m_shr, m_caps, m_held} = '0; m_last = 0;
  endtask

  task automatic drain;
    int n = 0;
    out_ready = 1;
    repeat (3) tick;
    while (out_valid && n < 40) begin tick; n++; end
    if (out_valid) begin total++; bad++; $display("FAIL drain_timeout: fifo_count %0d want 0", fifo_count); end
    out_ready = 0;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", out_data); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL rst_caps: got %b want 0", caps_state); end
    repeat (3) tick;
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL rst_discard: got %0d want 0", fifo_count); end
  endtask

  task automatic test_basic;
    int g0 = got.size(), e0 = exp_q.size();
    out_ready = 0;
    send(8'h1C);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", out_valid); end
    tick;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h61) begin bad++; $display("FAIL lat_first: got %b/%h want 1/61", out_valid, out_data); end
    total++; if (fifo_count !== 4'd1) begin bad++; $display("FAIL lat_count: got %0d want 1", fifo_count); end
    send(8'hF0); send(8'h1C);
    drain;
    total++; if (got.size()-g0 != 1 || got[g0] !== 8'h61) begin bad++; $display("FAIL basic: got %0d chars want one 61", got.size()-g0); end
    total++; if (exp_q.size()-e0 != 1) begin bad++; $display("FAIL basic_model: got %0d want 1", exp_q.size()-e0); end
    total++; if (fifo_count !== 4'd0) begin bad++; $display("FAIL basic_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_shift;
    int g0 = got.size(), e0 = exp_q.size();
    byte unsigned seq[18] = '{8'h12,8'h1C,8'hF0,8'h1C,8'hF0,8'h12,8'h1C,8'hF0,8'h1C,
                              8'h59,8'h32,8'hF0,8'h32,8'hF0,8'h59,8'h32,8'hF0,8'h32};
    out_ready = 1;
    foreach (seq[i]) send(seq[i]);
    drain;
    total++; if (got.size()-g0 != 4 || got[g0] !== 8'h41 || got[g0+1] !== 8'h61) begin bad++; $display("FAIL shift_fixed: got %0d chars want 4 starting 41 61", got.size()-g0); end
    total++; if (got.size()-g0 != exp_q.size()-e0) begin bad++; $display("FAIL shift_len: got %0d want %0d", got.size()-g0, exp_q.size()-e0); end
    for (int i = 0; i < exp_q.size()-e0 && g0+i < got.size(); i++) begin
      total++; if (got[g0+i] !== exp_q[e0+i]) begin bad++; $display("FAIL shift_char%0d: got %h want %h", i, got[g0+i], exp_q[e0+i]); end
    end
  endtask

  task automatic test_caps;
    int g0 = got.size(), e0 = exp_q.size();
    byte unsigned seq[10] = '{8'h1C,8'hF0,8'h1C,8'h12,8'h1C,8'hF0,8'h1C,8'hF0,8'h12,8'h00};
    send(8'h58); send(8'hF0); send(8'h58); tick;
    total++; if (caps_state !== 1'b1) begin bad++; $display("FAIL caps_on: got %b want 1", caps_state); end
    for (int i = 0; i < 9; i++) send(seq[i]);
    send(8'h58); send(8'hF0); send(8'h58); tick;
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL caps_off: got %b want 0", caps_state); end
    drain;
    total++; if (got.size()-g0 != 2 || got[g0] !== 8'h41 || got[g0+1] !== 8'h61) begin bad++; $display("FAIL caps_chars: got %0d chars want 41 61", got.size()-g0); end
    total++; if (got.size()-g0 != exp_q.size()-e0) begin bad++; $display("FAIL caps_len: got %0d want %0d", got.size()-g0, exp_q.size()-e0); end
  endtask

  task automatic test_extended;
    int g0 = got.size(), e0 = exp_q.size();
    byte unsigned seq[25] = '{8'hE0,8'h75,8'hE0,8'hF0,8'h75,8'hE0,8'h12,8'h1C,8'hF0,8'h1C,8'hE0,8'hF0,8'h12,
                              8'hE0,8'h58,8'hE0,8'hF0,8'h58,8'h12,8'h16,8'hF0,8'h16,8'hF0,8'h12,8'hE0};
    out_ready = 1;
    for (int i = 0; i < 24; i++) send(seq[i]);
    drain;
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL ext_caps: got %b want 0", caps_state); end
    total++; if (got.size()-g0 != exp_q.size()-e0) begin bad++; $display("FAIL ext_len: got %0d want %0d", got.size()-g0, exp_q.size()-e0); end
    for (int i = 0; i < exp_q.size()-e0 && g0+i < got.size(); i++) begin
      total++; if (got[g0+i] !== exp_q[e0+i]) begin bad++; $display("FAIL ext_char%0d: got %h want %h", i, got[g0+i], exp_q[e0+i]); end
    end
    total++; if (got.size()-g0 != 2 || got[g0+1] !== 8'h31) begin bad++; $display("FAIL ext_digit: got %0d chars want a then 31", got.size()-g0); end
  endtask

  task automatic test_overflow;
    int g0 = got.size(), e0 = exp_q.size(), o0 = ovf_cnt;
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin send(letters[i]); send(8'hF0); send(letters[i]); end
    repeat (3) tick;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d want 8", fifo_count); end
    total++; if (ovf_cnt - o0 != 1) begin bad++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_cnt - o0); end
    void'(exp_q.pop_back());
    drain;
    total++; if (got.size()-g0 != 8) begin bad++; $display("FAIL ovf_len: got %0d want 8", got.size()-g0); end
    for (int i = 0; i < exp_q.size()-e0 && g0+i < got.size(); i++) begin
      total++; if (got[g0+i] !== exp_q[e0+i]) begin bad++; $display("FAIL ovf_char%0d: got %h want %h", i, got[g0+i], exp_q[e0+i]); end
    end
  endtask

  task automatic test_back_to_back;
    int g0 = got.size(), e0 = exp_q.size(), o0 = ovf_cnt;
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin send(letters[i+10]); send(8'hF0); send(letters[i+10]); end
    repeat (3) tick;
    send(letters[20]);
    out_ready = 1; tick; out_ready = 0;
    repeat (2) tick;
    total++; if (fifo_count !== 4'd8) begin bad++; $display("FAIL full_pop_count: got %0d want 8", fifo_count); end
    total++; if (ovf_cnt - o0 != 0) begin bad++; $display("FAIL full_pop_ovf: got %0d pulses want 0", ovf_cnt - o0); end
    send(8'hF0); send(letters[20]);
    drain;
    total++; if (got.size()-g0 != 9) begin bad++; $display("FAIL full_pop_len: got %0d want 9", got.size()-g0); end
    for (int i = 0; i < exp_q.size()-e0 && g0+i < got.size(); i++) begin
      total++; if (got[g0+i] !== exp_q[e0+i]) begin bad++; $display("FAIL full_pop_char%0d: got %h want %h", i, got[g0+i], exp_q[e0+i]); end
    end
  endtask

  task automatic test_typematic;
    int g0 = got.size(), want_n;
`ifdef PS2_TYPEMATIC_EN
    want_n = 3;
`else
    want_n = 1;
`endif
    out_ready = 1;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
    drain;
    total++; if (got.size()-g0 != want_n) begin bad++; $display("FAIL repeat_count: got %0d chars want %0d", got.size()-g0, want_n); end
    for (int i = g0; i < got.size(); i++) begin
      total++; if (got[i] !== 8'h61) begin bad++; $display("FAIL repeat_char: got %h want 61", got[i]); end
    end
    send(8'h58); send(8'h58); tick;
    total++; if (caps_state !== 1'b1 || m_caps !== 1'b1) begin bad++; $display("FAIL caps_repeat: got %b want 1", caps_state); end
    send(8'hF0); send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58); tick;
    total++; if (caps_state !== 1'b0) begin bad++; $display("FAIL caps_repeat_off: got %b want 0", caps_state); end
  endtask

  task automatic test_random;
    int g0 = got.size(), e0 = exp_q.size(), o0 = ovf_cnt;
    byte unsigned b;
    for (int k = 0; k < 400; k++) begin
      out_ready = fifo_count >= 4 ? 1'b1 : 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) tick;
      else begin
        case ($urandom_range(0, 5))
          0, 1: b = letters[$urandom_range(0, 25)];
          2: b = digits[$urandom_range(0, 9)];
          3: b = $urandom_range(0, 1) ? 8'hF0 : 8'hE0;
          4: b = mods[$urandom_range(0, 5)];
          default: b = 8'($urandom);
        endcase
        send(b);
      end
    end
    drain;
    total++; if (ovf_cnt - o0 != 0) begin bad++; $display("FAIL rand_ovf: got %0d pulses want 0", ovf_cnt - o0); end
    total++; if (caps_state !== m_caps) begin bad++; $display("FAIL rand_caps: got %b want %b", caps_state, m_caps); end
    total++; if (got.size()-g0 != exp_q.size()-e0) begin bad++; $display("FAIL rand_len: got %0d want %0d", got.size()-g0, exp_q.size()-e0); end
    for (int i = 0; i < exp_q.size()-e0 && g0+i < got.size(); i++) begin
      total++; if (got[g0+i] !== exp_q[e0+i]) begin bad++; $display("FAIL rand_char%0d: got %h want %h", i, got[g0+i], exp_q[e0+i]); end
    end
  endtask

  task automatic test_reset_mid;
    int g0, e0;
    out_ready = 1;
    send(8'hF0);
    do_reset;
    g0 = got.size(); e0 = exp_q.size();
    send(8'h1C); send(8'hF0); send(8'h1C);
    drain;
    total++; if (got.size()-g0 != 1 || got[g0] !== 8'h61) begin bad++; $display("FAIL reset_mid: got %0d chars want one 61", got.size()-g0); end
    total++; if (exp_q.size()-e0 != 1) begin bad++; $display("FAIL reset_mid_model: got %0d want 1", exp_q.size()-e0); end
  endtask

  initial begin
    tick;
    test_reset;
    test_basic;
    test_shift;
    test_caps;
    test_extended;
    test_overflow;
    test_back_to_back;
    test_typematic;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_ascii_decode.md
Name: ps2_ascii_decode

Overview:
- Sits between the PS/2 scan-byte receiver and the UART transmitter in the keyboard-to-serial path.
- Consumes raw set-2 scan bytes and tracks make/break/extended prefixes, Shift and Caps Lock state.
- Translates key presses to ASCII and buffers characters in a small FIFO, so bursts of keystrokes are not lost while the UART is busy.

Parameters:
- ADDR_W, 3, FIFO address width; depth = 2**ADDR_W entries of 8 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- scan_byte  input  8  received PS/2 byte
- scan_valid  input  1  one-cycle strobe; scan_byte valid this cycle
- out_data  output  8  ASCII character at FIFO head
- out_valid  output  1  FIFO not empty
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready
- fifo_count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W
- overflow  output  1  one-cycle pulse when a character is dropped because the FIFO is full
- caps_state  output  1  current Caps Lock toggle state

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). All state changes on the rising clk edge.
- Reset: FSM to IDLE; shift_l, shift_r, caps_state, caps_held cleared; FIFO pointers cleared; out_valid=0, out_data=0x00, fifo_count=0, overflow=0.
- Prefix FSM states:
  - IDLE. Byte 0xE0 goes to EXT. Byte 0xF0 goes to BRK. Any other byte is a make code: process it and stay in IDLE.
  - EXT. Byte 0xF0 goes to EXT_BRK. Any other byte is an extended make: ignored, return to IDLE.
  - BRK. Any byte is a break code: process the release, return to IDLE.
  - EXT_BRK. Any byte is an extended break: ignored, return to IDLE.
- Extended keys never affect shift or caps state.
- Make handling:
  - 0x12 sets shift_l; 0x59 sets shift_r.
  - 0x58: if caps_held=0, toggle caps_state and set caps_held; if caps_held=1, do nothing. Auto-repeat never re-toggles.
  - Mapped keys emit one character; unmapped codes are ignored.
- Break handling: 0x12 clears shift_l; 0x59 clears shift_r; 0x58 clears caps_held. No character is emitted on any break.
- Letter map (code to letter):
  - 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M
  - 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z
  - Output is uppercase (0x41+) when (shift_l|shift_r) XOR caps_state, otherwise lowercase (0x61+).
- Other map (shift-independent):
  - Digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'.
  - 29 space 0x20; 5A 0x0D; 66 0x08.
- Pipeline: the decode stage registers {char, char_valid} one edge after scan_valid is sampled. The FIFO write happens on the next edge. out_valid is asserted 2 cycles after the scan_valid cycle if the FIFO was empty.
- FIFO:
  - Show-ahead: out_data always reflects the head entry.
  - A pop happens on out_valid && out_ready.
  - Push while full with no pop: the character is dropped, overflow pulses for 1 cycle, and contents are unchanged.
  - Push and pop in the same cycle while full: both are accepted and count is unchanged.
  - Push and pop in the same cycle while empty: only the push happens (no pop, since out_valid=0).
  - Pointers wrap modulo 2**ADDR_W; fifo_count uses an extra bit to distinguish full from empty.
- A scan_valid during reset is discarded. Reset mid-sequence (e.g. after 0xF0) returns to IDLE, so the next byte is treated as a make.

Optional Feature:
- Macro: PS2_TYPEMATIC_EN.
- Defined: every make of a mapped key emits a character, including typematic repeats.
- Undefined:
  - A last_make register (reset 0x00) holds the most recent mapped make code.
  - A make equal to last_make is suppressed.
  - A break of last_make clears it to 0x00.
  - A different mapped make emits its character and replaces last_make.

Test Plan:
- Reset then bytes 1C, F0 1C with out_ready=1 -> exactly one out_data=0x61 ('a'); nothing on the break; fifo_count returns to 0.
- 12, 1C, F0 12, 1C -> 0x41 then 0x61. 58, F0 58, 1C -> caps_state=1, 0x41. With 12 held as well -> 0x61.
- E0 75, E0 F0 75, then 12 16 -> no output for the extended key; '1' emitted as 0x31, unaffected by shift.
- out_ready=0, send 9 distinct letters with ADDR_W=3 -> fifo_count=8, one overflow pulse on the 9th; draining yields the first 8 in order.
- FIFO full with out_ready=1 in the same cycle as a new push -> no overflow, fifo_count stays 8, data order preserved.
- 1C 1C 1C then F0 1C -> three 'a' with PS2_TYPEMATIC_EN defined, one 'a' without it. Send 58 twice -> caps_state toggles only once in both builds.
